issue_ctrl: RTL and testbench
=============================

ISSUE_CTRL -- requirements
Module: issue_ctrl

Interface
REQ-001 SHALL have parameter: OUTST_MAX, 4, max in-flight long-latency ops (1..15).
REQ-002 SHALL have port: clk  in  1  sole clock; all state on rising edge.
REQ-003 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: id_valid_i in 1 decoded instr present; id_ready_o out 1 issue stage accepts it.
REQ-005 SHALL have ports: id_rs1_en_i/id_rs2_en_i/id_rd_en_i in 1 each; id_rs1_idx_i/id_rs2_idx_i/id_rd_idx_i in 5 each: decoder operand usage.
REQ-006 SHALL have port: id_long_lat_i  in  1  instr is load or CSR (result returns via wb port).
REQ-007 SHALL have ports: issue_valid_o out 1 instr to ex; ex_ready_i in 1 ex accepts.
REQ-008 SHALL have ports: wb_valid_i in 1, wb_idx_i in 5: long-latency result written this cycle.
REQ-009 SHALL have ports: flush_i in 1 kill current instr; drain_i in 1 fence request; drain_done_o out 1.
REQ-010 SHALL have port: sb_err_o  out  1  sticky protocol error.

Function
REQ-011 Scoreboard sb[31:1] SHALL mark registers with pending long-latency writes; x0 never marked, never hazards.
REQ-012 hazard SHALL = (rs1_en & sb[rs1]) | (rs2_en & sb[rs2]) | (rd_en & sb[rd]) (RAW + WAW).
REQ-013 full SHALL = id_long_lat_i & (outst_cnt == OUTST_MAX).
REQ-014 issue_valid_o SHALL = id_valid_i & ~hazard & ~full & ~flush_i & (state==IDLE), combinational.
REQ-015 id_ready_o SHALL = ex_ready_i & ~hazard & ~full & (state==IDLE) | flush_i; flush consumes instr without issue.
REQ-016 fire = issue_valid_o & ex_ready_i; on fire with long_lat & rd_en & rd!=0, sb[rd] SHALL set next edge.
REQ-017 On fire with long_lat, outst_cnt SHALL +1; on wb_valid_i, -1; both same cycle: unchanged.
REQ-018 wb_valid_i SHALL clear sb[wb_idx] at next edge; no same-cycle bypass (hazard released one cycle after wb).
REQ-019 wb_valid_i with outst_cnt==0 SHALL be ignored for the counter and set sb_err_o; sb_err_o cleared only by reset.
REQ-020 Long op with rd_en=0 or rd=x0 SHALL count in outst_cnt and its wb SHALL use wb_idx=0 (no sb change).
REQ-021 FSM IDLE->DRAIN on drain_i; DRAIN->DONE when outst_cnt==0; DONE->IDLE next cycle; drain_i in DRAIN/DONE ignored.
REQ-022 drain_done_o SHALL be 1 exactly one cycle in DONE; issue blocked in DRAIN and DONE.
REQ-023 drain_i with outst_cnt already 0 SHALL reach DONE after 2 edges (IDLE->DRAIN->DONE).
REQ-024 flush_i SHALL NOT clear sb or outst_cnt (in-flight ops still write back).

Reset
REQ-025 rst_n low SHALL asynchronously clear sb, outst_cnt, sb_err_o, stall counter; state=IDLE.
REQ-026 During reset, issue_valid_o, id_ready_o, drain_done_o SHALL be 0; wb during reset discarded.

Configuration
REQ-027 Macro ISSUE_PERF_EN defined: SHALL add output stall_cnt_o (32) incrementing each cycle id_valid_i & ~issue_valid_o & ~flush_i, saturating at all-ones.
REQ-028 Macro ISSUE_PERF_EN undefined: port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-029 FSM state encodings (IDLE/DRAIN/DONE) and outst_cnt width SHALL live in shared defines.v.
REQ-030 Scoreboard SHALL be sub-module issue_sb (set port, clear port, 31-bit state, 3 read ports).

Verification
REQ-031 Load rd=x5 fires; next instr add rs1=x5 -> issue_valid_o=0 until cycle after wb_valid_i, wb_idx=5.
REQ-032 OUTST_MAX=4: issue 4 loads to x1..x4, 5th load to x6 stalls; one wb -> 5th issues following cycle.
REQ-033 Same-cycle long fire and wb_valid_i -> outst_cnt unchanged; sb reflects both set and clear.
REQ-034 drain_i with 2 loads outstanding -> drain_done_o pulses 1 cycle after the 2nd wb; no issue meanwhile.
REQ-035 wb_valid_i at outst_cnt=0 -> sb_err_o=1 and holds; rst_n low mid-drain -> IDLE, all outputs 0.
REQ-036 ISSUE_PERF_EN: 3 hazard stall cycles -> stall_cnt_o=3; flush_i cycle not counted.

Source files
------------

// File: rtl/issue_ctrl_pkg.sv
// Shared types for the issue controller: FSM state encoding and outstanding-op counter width.
package issue_ctrl_pkg;

  localparam int unsigned OUTST_W = 4;

  typedef logic [OUTST_W-1:0] outst_cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } issue_state_e;

endpackage

// File: rtl/issue_ctrl_sb.sv
// Register scoreboard: one pending bit per x1..x31, single set and clear port, three read ports.
module issue_sb
  import issue_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_en,
  input  logic [4:0] set_idx,
  input  logic       clr_en,
  input  logic [4:0] clr_idx,
  input  logic [4:0] rd_idx_a,
  input  logic [4:0] rd_idx_b,
  input  logic [4:0] rd_idx_c,
  output logic       rd_a,
  output logic       rd_b,
  output logic       rd_c
);

  logic [31:1] sb_q;
  logic [31:1] sb_d;
  logic [31:0] sb_view;

  // x0 reads as a hard zero so callers never need to special-case it
  assign sb_view = {sb_q, 1'b0};
  assign rd_a    = sb_view[rd_idx_a];
  assign rd_b    = sb_view[rd_idx_b];
  assign rd_c    = sb_view[rd_idx_c];

  always_comb begin
    sb_d = sb_q;
    for (int unsigned i = 1; i < 32; i++) begin
      if (clr_en && (clr_idx == 5'(i))) sb_d[i] = 1'b0;
      if (set_en && (set_idx == 5'(i))) sb_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sb_q <= '0;
    else        sb_q <= sb_d;
  end

endmodule

// File: rtl/issue_ctrl.sv
// In-order issue gate with RAW/WAW scoreboard, long-latency op limit and drain/fence FSM.
// Optional stall performance counter enabled by defining ISSUE_PERF_EN.
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int unsigned OUTST_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid_i,
  output logic        id_ready_o,
  input  logic        id_rs1_en_i,
  input  logic        id_rs2_en_i,
  input  logic        id_rd_en_i,
  input  logic [4:0]  id_rs1_idx_i,
  input  logic [4:0]  id_rs2_idx_i,
  input  logic [4:0]  id_rd_idx_i,
  input  logic        id_long_lat_i,
  output logic        issue_valid_o,
  input  logic        ex_ready_i,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_idx_i,
  input  logic        flush_i,
  input  logic        drain_i,
  output logic        drain_done_o,
  output logic        sb_err_o
`ifdef ISSUE_PERF_EN
  ,
  output logic [31:0] stall_cnt_o
`endif
);

  issue_state_e state_q, state_d;
  outst_cnt_t   outst_cnt;
  logic         hit_rs1, hit_rs2, hit_rd;
  logic         hazard, full, idle;
  logic         fire, long_fire, wb_ok;

  issue_sb u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (long_fire & id_rd_en_i & (id_rd_idx_i != 5'd0)),
    .set_idx  (id_rd_idx_i),
    .clr_en   (wb_valid_i),
    .clr_idx  (wb_idx_i),
    .rd_idx_a (id_rs1_idx_i),
    .rd_idx_b (id_rs2_idx_i),
    .rd_idx_c (id_rd_idx_i),
    .rd_a     (hit_rs1),
    .rd_b     (hit_rs2),
    .rd_c     (hit_rd)
  );

  assign hazard = (id_rs1_en_i & hit_rs1) | (id_rs2_en_i & hit_rs2) | (id_rd_en_i & hit_rd);
  assign full   = id_long_lat_i & (outst_cnt == OUTST_W'(OUTST_MAX));
  assign idle   = (state_q == ST_IDLE);

  // rst_n gating keeps the handshake quiet while reset is held
  assign issue_valid_o = rst_n & id_valid_i & ~hazard & ~full & ~flush_i & idle;
  assign id_ready_o    = rst_n & ((ex_ready_i & ~hazard & ~full & idle) | flush_i);

  assign fire      = issue_valid_o & ex_ready_i;
  assign long_fire = fire & id_long_lat_i;
  assign wb_ok     = wb_valid_i & (outst_cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outst_cnt <= '0;
      sb_err_o  <= 1'b0;
    end else begin
      case ({long_fire, wb_ok})
        2'b10:   outst_cnt <= outst_cnt + 1'b1;
        2'b01:   outst_cnt <= outst_cnt - 1'b1;
        default: outst_cnt <= outst_cnt;
      endcase
      if (wb_valid_i && (outst_cnt == '0)) sb_err_o <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    drain_done_o = 1'b0;
    case (state_q)
      ST_IDLE:  if (drain_i) state_d = ST_DRAIN;
      ST_DRAIN: if (outst_cnt == '0) state_d = ST_DONE;
      ST_DONE: begin
        drain_done_o = 1'b1;
        state_d      = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

`ifdef ISSUE_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_o <= '0;
    end else if (id_valid_i && !issue_valid_o && !flush_i && (stall_cnt_o != '1)) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_issue_ctrl.sv
// Self-checking bench for issue_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_issue_ctrl;

  localparam int OUTST = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid_i = 1'b0, id_ready_o;
  logic       id_rs1_en_i = 1'b0, id_rs2_en_i = 1'b0, id_rd_en_i = 1'b0;
  logic [4:0] id_rs1_idx_i = '0, id_rs2_idx_i = '0, id_rd_idx_i = '0;
  logic       id_long_lat_i = 1'b0, issue_valid_o, ex_ready_i = 1'b0;
  logic       wb_valid_i = 1'b0;
  logic [4:0] wb_idx_i = '0;
  logic       flush_i = 1'b0, drain_i = 1'b0, drain_done_o, sb_err_o;
`ifdef ISSUE_PERF_EN
  logic [31:0] stall_cnt_o;
`endif

  issue_ctrl #(.OUTST_MAX(OUTST)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
    .id_rs1_en_i(id_rs1_en_i), .id_rs2_en_i(id_rs2_en_i), .id_rd_en_i(id_rd_en_i),
    .id_rs1_idx_i(id_rs1_idx_i), .id_rs2_idx_i(id_rs2_idx_i), .id_rd_idx_i(id_rd_idx_i),
    .id_long_lat_i(id_long_lat_i), .issue_valid_o(issue_valid_o), .ex_ready_i(ex_ready_i),
    .wb_valid_i(wb_valid_i), .wb_idx_i(wb_idx_i),
    .flush_i(flush_i), .drain_i(drain_i), .drain_done_o(drain_done_o),
    .sb_err_o(sb_err_o)
`ifdef ISSUE_PERF_EN
    , .stall_cnt_o(stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // behavioural model: pending set of registers, in-flight list, drain mode 0=run 1=waiting 2=done
  bit          pend[32];
  int          inflight[$];
  int          mode;
  bit          err;
  int unsigned stall;

  logic obs_iv, obs_rdy, obs_done, obs_err;
  logic [31:0] obs_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (pend[i]) pend[i] = 1'b0;
    inflight.delete();
    mode = 0;
    err = 1'b0;
    stall = 0;
  endtask

  task automatic idle_in();
    id_valid_i = 0; id_rs1_en_i = 0; id_rs2_en_i = 0; id_rd_en_i = 0;
    id_rs1_idx_i = 0; id_rs2_idx_i = 0; id_rd_idx_i = 0;
    id_long_lat_i = 0; ex_ready_i = 0; wb_valid_i = 0; wb_idx_i = 0;
    flush_i = 0; drain_i = 0;
  endtask

  // one clock: compare outputs at negedge against the model, then advance the model
  task automatic cyc();
    bit haz, full, e_iv, e_rdy, fire;
    int n;
    @(negedge clk);
    haz  = (id_rs1_en_i && pend[id_rs1_idx_i] && id_rs1_idx_i != 0) ||
           (id_rs2_en_i && pend[id_rs2_idx_i] && id_rs2_idx_i != 0) ||
           (id_rd_en_i  && pend[id_rd_idx_i]  && id_rd_idx_i  != 0);
    full = id_long_lat_i && (inflight.size() == OUTST);
    e_iv  = id_valid_i && !haz && !full && !flush_i && mode == 0;
    e_rdy = (ex_ready_i && !haz && !full && mode == 0) || flush_i;
    obs_iv = issue_valid_o; obs_rdy = id_ready_o; obs_done = drain_done_o; obs_err = sb_err_o;
    chk("issue_valid", {31'd0, issue_valid_o}, {31'd0, e_iv});
    chk("id_ready", {31'd0, id_ready_o}, {31'd0, e_rdy});
    chk("drain_done", {31'd0, drain_done_o}, {31'd0, mode == 2});
    chk("sb_err", {31'd0, sb_err_o}, {31'd0, err});
`ifdef ISSUE_PERF_EN
    obs_stall = stall_cnt_o;
    chk("stall_cnt", stall_cnt_o, stall);
    if (id_valid_i && !e_iv && !flush_i && stall != 32'hFFFF_FFFF) stall++;
`else
    obs_stall = '0;
`endif
    fire = e_iv && ex_ready_i;
    n = inflight.size();
    case (mode)
      0: if (drain_i) mode = 1;
      1: if (n == 0) mode = 2;
      default: mode = 0;
    endcase
    if (wb_valid_i) begin
      if (wb_idx_i != 0) pend[wb_idx_i] = 1'b0;
      if (n == 0) err = 1'b1;
      else begin
        for (int k = 0; k < inflight.size(); k++)
          if (inflight[k] == int'(wb_idx_i)) begin inflight.delete(k); break; end
      end
    end
    if (fire && id_long_lat_i) begin
      if (id_rd_en_i && id_rd_idx_i != 0) begin
        pend[id_rd_idx_i] = 1'b1;
        inflight.push_back(int'(id_rd_idx_i));
      end else inflight.push_back(0);
    end
    @(posedge clk);
    #1;
  endtask

  // asserts reset mid-cycle with aggressive inputs; outputs must be quiet immediately
  task automatic do_reset();
    rst_n = 0;
    id_valid_i = 1; flush_i = 1; ex_ready_i = 1; wb_valid_i = 1; wb_idx_i = 5'd3; drain_i = 1;
    #1;
    chk("rst_issue_valid", {31'd0, issue_valid_o}, 32'd0);
    chk("rst_id_ready", {31'd0, id_ready_o}, 32'd0);
    chk("rst_drain_done", {31'd0, drain_done_o}, 32'd0);
    chk("rst_sb_err", {31'd0, sb_err_o}, 32'd0);
`ifdef ISSUE_PERF_EN
    chk("rst_stall_cnt", stall_cnt_o, 32'd0);
`endif
    @(posedge clk);
    @(negedge clk);
    idle_in();
    rst_n = 1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int rd);
    idle_in(); id_valid_i = 1; id_long_lat_i = 1; id_rd_en_i = 1; id_rd_idx_i = 5'(rd); ex_ready_i = 1;
  endtask

  task automatic alu(input int rs1);
    idle_in(); id_valid_i = 1; id_rs1_en_i = 1; id_rs1_idx_i = 5'(rs1);
    id_rd_en_i = 1; id_rd_idx_i = 5'd20; ex_ready_i = 1;
  endtask

  initial begin
    idle_in();
    model_reset();
    #12;
    do_reset();

    // RAW stall on a pending load result, released one cycle after its writeback
    load(5); cyc(); chk("ld_x5_issue", {31'd0, obs_iv}, 32'd1);
    alu(5); cyc(); chk("raw_stall", {31'd0, obs_iv}, 32'd0);
    wb_valid_i = 1; wb_idx_i = 5'd5; cyc(); chk("raw_no_bypass", {31'd0, obs_iv}, 32'd0);
    wb_valid_i = 0; cyc(); chk("raw_release", {31'd0, obs_iv}, 32'd1);

    // outstanding limit
    do_reset();
    for (int i = 1; i <= 4; i++) begin load(i); cyc(); chk("fill_issue", {31'd0, obs_iv}, 32'd1); end
    load(6); cyc(); chk("full_stall", {31'd0, obs_iv}, 32'd0);
    wb_valid_i = 1; wb_idx_i = 5'd1; cyc(); chk("full_wb_cycle", {31'd0, obs_iv}, 32'd0);
    wb_valid_i = 0; cyc(); chk("full_release", {31'd0, obs_iv}, 32'd1);

    // simultaneous long fire and writeback keep the count; sb shows both edits
    idle_in(); wb_valid_i = 1; wb_idx_i = 5'd2; cyc();
    load(7); wb_valid_i = 1; wb_idx_i = 5'd3; cyc(); chk("same_cycle_fire", {31'd0, obs_iv}, 32'd1);
    alu(3); cyc(); chk("sb_cleared_x3", {31'd0, obs_iv}, 32'd1);
    alu(7); cyc(); chk("sb_set_x7", {31'd0, obs_iv}, 32'd0);
    idle_in(); id_valid_i = 1; id_long_lat_i = 1; ex_ready_i = 1; cyc();
    chk("nord_long_issue", {31'd0, obs_iv}, 32'd1);
    cyc(); chk("count_reaches_max", {31'd0, obs_iv}, 32'd0);

    // drain with two loads outstanding
    do_reset();
    load(1); cyc(); load(2); cyc();
    idle_in(); drain_i = 1; cyc();
    alu(9); cyc(); chk("drain_block", {31'd0, obs_iv}, 32'd0);
    wb_valid_i = 1; wb_idx_i = 5'd1; cyc(); chk("drain_wb1", {31'd0, obs_iv}, 32'd0);
    wb_idx_i = 5'd2; cyc(); chk("drain_wb2_done", {31'd0, obs_done}, 32'd0);
    wb_valid_i = 0; cyc(); chk("drain_wait_done", {31'd0, obs_done}, 32'd0);
    chk("drain_wait_block", {31'd0, obs_iv}, 32'd0);
    cyc(); chk("drain_done_pulse", {31'd0, obs_done}, 32'd1);
    chk("done_block", {31'd0, obs_iv}, 32'd0);
    cyc(); chk("done_clears", {31'd0, obs_done}, 32'd0);
    chk("issue_after_drain", {31'd0, obs_iv}, 32'd1);

    // drain when already empty: DONE after two edges
    idle_in(); drain_i = 1; cyc();
    drain_i = 0; cyc(); chk("empty_drain_mid", {31'd0, obs_done}, 32'd0);
    cyc(); chk("empty_drain_done", {31'd0, obs_done}, 32'd1);

    // spurious writeback sets a sticky error; reset mid-drain clears everything
    do_reset();
    idle_in(); wb_valid_i = 1; wb_idx_i = 5'd0; cyc();
    idle_in(); cyc(); chk("err_set", {31'd0, obs_err}, 32'd1);
    cyc(); chk("err_sticky", {31'd0, obs_err}, 32'd1);
    load(4); cyc();
    idle_in(); drain_i = 1; cyc();
    idle_in(); cyc();
    do_reset();
    cyc(); chk("post_rst_err", {31'd0, obs_err}, 32'd0);
    chk("post_rst_done", {31'd0, obs_done}, 32'd0);

`ifdef ISSUE_PERF_EN
    do_reset();
    load(5); cyc();
    for (int i = 0; i < 3; i++) begin alu(5); cyc(); end
    alu(5); flush_i = 1; cyc();
    idle_in(); cyc(); chk("stall_cnt_three", obs_stall, 32'd3);
`endif

    // randomized traffic
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      if (n % 1000 == 999) do_reset();
      idle_in();
      id_valid_i    = ($urandom_range(0, 9) < 7);
      id_rs1_en_i   = $urandom_range(0, 1);
      id_rs2_en_i   = $urandom_range(0, 1);
      id_rd_en_i    = ($urandom_range(0, 3) != 0);
      id_rs1_idx_i  = 5'($urandom_range(0, 7));
      id_rs2_idx_i  = 5'($urandom_range(0, 7));
      id_rd_idx_i   = 5'($urandom_range(0, 7));
      id_long_lat_i = ($urandom_range(0, 9) < 4);
      ex_ready_i    = ($urandom_range(0, 9) < 8);
      flush_i       = ($urandom_range(0, 19) == 0);
      drain_i       = ($urandom_range(0, 39) == 0);
      if (inflight.size() > 0 && $urandom_range(0, 99) < 35) begin
        wb_valid_i = 1;
        wb_idx_i   = 5'(inflight[$urandom_range(0, inflight.size() - 1)]);
      end
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
